fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end: generates instruction-memory requests, buffers returned words with their PCs in a DEPTH-entry FIFO, and presents them to the decoder over a valid/ready handshake.
- Supports variable-latency in-order memory, multiple outstanding requests, and single-cycle redirect/flush from the execute stage.
- Replaces the counter-based branch stall with a flush-and-discard scheme.
- Sits between instruction memory and the decoder.

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues IMEM requests, queues returned words with their PCs, and hands them to the decoder.
// Latency: request in n -> response n+1 (1-cycle memory) -> INST_VALID n+2; redirect at t -> new instruction valid at t+3.
// Backpressure: INST_READY low holds the head; requests stop once queued + in-flight words reach DEPTH (credit check).
//
// Ports:
//   CLK, RSTN                     clock (rising edge), asynchronous active-low reset
//   IMEM_REQ/IMEM_ADDR            fetch request and address, accepted every cycle IMEM_REQ is high
//   IMEM_RVALID/IMEM_RDATA        in-order response from instruction memory
//   REDIRECT_VALID/REDIRECT_PC    flush everything and restart fetch at REDIRECT_PC
//   INST_VALID/INST/INST_PC       queue head towards the decoder
//   INST_READY                    decoder accepts the head
//   COUNT                         queue occupancy
module fetch_queue #(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       PC_INC   = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  output logic                       IMEM_REQ,
  output logic [ADDR_W-1:0]          IMEM_ADDR,
  input  logic                       IMEM_RVALID,
  input  logic [XLEN-1:0]            IMEM_RDATA,
  input  logic                       REDIRECT_VALID,
  input  logic [ADDR_W-1:0]          REDIRECT_PC,
  output logic                       INST_VALID,
  output logic [XLEN-1:0]            INST,
  output logic [ADDR_W-1:0]          INST_PC,
  input  logic                       INST_READY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int unsigned       CW  = $clog2(DEPTH + 1);
  localparam int unsigned       PW  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

  logic [XLEN-1:0]   inst_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

  logic [CW:0] credit_used;
  logic        issue, resp, push, pop;

  // Every queued or outstanding word holds a slot, so a push can never find the queue full.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign IMEM_REQ    = RSTN & ~REDIRECT_VALID & (credit_used < (CW + 1)'(DEPTH));
  assign IMEM_ADDR   = fetch_pc_q;
  assign issue       = IMEM_REQ;

  // A response with nothing outstanding (e.g. one issued before a reset) is ignored.
  assign resp = IMEM_RVALID & (inflight_q != '0);
  assign push = resp & (discard_q == '0) & ~REDIRECT_VALID;

  assign INST_VALID = (count_q != '0) & ~REDIRECT_VALID;
  assign pop        = INST_VALID & INST_READY;
  assign INST       = inst_mem_q[rd_ptr_q];
  assign INST_PC    = pc_mem_q[rd_ptr_q];
  assign COUNT      = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = inflight_q + CW'(issue) - CW'(resp);

    if (REDIRECT_VALID) begin
      fetch_pc_d = REDIRECT_PC;
      resp_pc_d  = REDIRECT_PC;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Every word still outstanding after this cycle belongs to the old stream,
      // including ones already marked for discard, so discard tracks inflight exactly.
      discard_d  = inflight_q - CW'(resp);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + INC;
      if (resp && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + INC;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: COUNT gates its visibility.
  always_ff @(posedge CLK) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= IMEM_RDATA;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, redir, ready, rvalid;
  logic [31:0] rpc, rdata;

  logic        a_req, a_vld;
  logic [31:0] a_addr, a_inst, a_pc;
  logic [2:0]  a_cnt;
  logic        b_req, b_vld;
  logic [7:0]  b_addr, b_pc;
  logic [31:0] b_inst;
  logic [2:0]  b_cnt;

  fetch_queue #(.XLEN(32), .ADDR_W(32), .DEPTH(4), .PC_INC(1), .RESET_PC(32'h0)) dut_a (
    .CLK(clk), .RSTN(rstn), .IMEM_REQ(a_req), .IMEM_ADDR(a_addr),
    .IMEM_RVALID(rvalid), .IMEM_RDATA(rdata), .REDIRECT_VALID(redir), .REDIRECT_PC(rpc),
    .INST_VALID(a_vld), .INST(a_inst), .INST_PC(a_pc), .INST_READY(ready), .COUNT(a_cnt));

  // Same control stream, 8-bit byte-addressed PCs starting near the top to exercise wrap-around.
  fetch_queue #(.XLEN(32), .ADDR_W(8), .DEPTH(4), .PC_INC(4), .RESET_PC(8'hF8)) dut_b (
    .CLK(clk), .RSTN(rstn), .IMEM_REQ(b_req), .IMEM_ADDR(b_addr),
    .IMEM_RVALID(rvalid), .IMEM_RDATA(rdata), .REDIRECT_VALID(redir), .REDIRECT_PC(rpc[7:0]),
    .INST_VALID(b_vld), .INST(b_inst), .INST_PC(b_pc), .INST_READY(ready), .COUNT(b_cnt));

  typedef struct { int due; logic [31:0] addr; int epoch; } req_t;
  typedef struct { logic [31:0] inst; logic [31:0] pca; logic [7:0] pcb; } exp_t;
  typedef struct { bit ready; bit e_req; logic [31:0] e_addr; bit e_vld; logic [31:0] e_pc; int e_cnt; } vec_t;

  req_t        memq[$];
  logic [31:0] stale[$];
  exp_t        sb[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, lat = 1, epoch = 0;
  logic [31:0] fa, ra;
  logic [7:0]  fb, rb;

  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pc, s_inst;
  logic [7:0]  s_bpc;
  logic [2:0]  s_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
  endtask

  // One clock cycle: memory model drives the response, DUT outputs are checked against
  // the epoch-based reference model, then the model advances as the clock edge will.
  task automatic cycle();
    req_t        r;
    logic [31:0] sa;
    bit          live, e_req, e_vld;
    int          infl;
    if (!rstn) begin
      foreach (memq[i]) stale.push_back(memq[i].addr);
      memq.delete();
      sb.delete();
      fa = 32'h0; ra = 32'h0; fb = 8'hF8; rb = 8'hF8;
    end
    infl  = memq.size();
    e_req = rstn && !redir && (sb.size() + infl < 4);
    e_vld = rstn && !redir && (sb.size() != 0);
    live = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    if (stale.size() > 0) begin
      sa = stale.pop_front();
      rvalid = 1'b1; rdata = 32'hDEAD_0000 | sa;
    end else if (memq.size() > 0 && memq[0].due <= cyc) begin
      r = memq.pop_front();
      rvalid = 1'b1; rdata = 32'h1000_0000 | r.addr; live = 1'b1;
    end
    #1;
    s_req = a_req; s_vld = a_vld; s_addr = a_addr; s_pc = a_pc; s_inst = a_inst;
    s_bpc = b_pc; s_cnt = a_cnt;
    chk("a_imem_req", {31'b0, a_req}, {31'b0, e_req});
    chk("b_imem_req", {31'b0, b_req}, {31'b0, e_req});
    chk("a_inst_valid", {31'b0, a_vld}, {31'b0, e_vld});
    chk("b_inst_valid", {31'b0, b_vld}, {31'b0, e_vld});
    chk("a_count", {29'b0, a_cnt}, sb.size());
    chk("b_count", {29'b0, b_cnt}, sb.size());
    if (e_req) begin
      chk("a_imem_addr", a_addr, fa);
      chk("b_imem_addr", {24'b0, b_addr}, {24'b0, fb});
    end
    if (e_vld) begin
      chk("a_inst", a_inst, sb[0].inst);
      chk("a_inst_pc", a_pc, sb[0].pca);
      chk("b_inst", b_inst, sb[0].inst);
      chk("b_inst_pc", {24'b0, b_pc}, {24'b0, sb[0].pcb});
    end
    if (e_vld && ready) void'(sb.pop_front());
    if (live && r.epoch == epoch && !redir) begin
      sb.push_back('{rdata, ra, rb});
      ra = ra + 32'd1; rb = rb + 8'd4;
    end
    if (redir && rstn) begin
      sb.delete(); epoch++;
      fa = rpc; ra = rpc; fb = rpc[7:0]; rb = rpc[7:0];
    end
    if (e_req) begin
      memq.push_back('{cyc + lat, fa, epoch});
      fa = fa + 32'd1; fb = fb + 8'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Runs until INST_VALID is seen; returns the number of cycles taken (0 if the bound expired).
  task automatic run_until_valid(input int max, input string nm, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!s_vld && n < max);
    if (!s_vld) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
      n = 0;
    end
  endtask

  vec_t vt[12];

  initial begin
    int n;
    int got;
    logic [31:0] pa[3];
    logic [7:0]  pb[3];

    // READY held low from reset with 1-cycle memory, then released.
    vt[0]  = '{0, 1, 32'd0, 0, 32'd0, 0};
    vt[1]  = '{0, 1, 32'd1, 0, 32'd0, 0};
    vt[2]  = '{0, 1, 32'd2, 1, 32'd0, 1};
    vt[3]  = '{0, 1, 32'd3, 1, 32'd0, 2};
    vt[4]  = '{0, 0, 32'd0, 1, 32'd0, 3};
    vt[5]  = '{0, 0, 32'd0, 1, 32'd0, 4};
    vt[6]  = '{0, 0, 32'd0, 1, 32'd0, 4};
    vt[7]  = '{1, 0, 32'd0, 1, 32'd0, 4};
    vt[8]  = '{1, 1, 32'd4, 1, 32'd1, 3};
    vt[9]  = '{1, 1, 32'd5, 1, 32'd2, 2};
    vt[10] = '{1, 1, 32'd6, 1, 32'd3, 2};
    vt[11] = '{1, 1, 32'd7, 1, 32'd4, 2};

    rstn = 1'b0; redir = 1'b0; rpc = 32'h0; ready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    @(negedge clk);
    run(2);
    chk("reset_req", {31'b0, s_req}, 32'd0);
    chk("reset_valid", {31'b0, s_vld}, 32'd0);
    chk("reset_count", {29'b0, s_cnt}, 32'd0);

    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ready = vt[i].ready;
      cycle();
      chk($sformatf("vec%0d_req", i), {31'b0, s_req}, {31'b0, vt[i].e_req});
      chk($sformatf("vec%0d_valid", i), {31'b0, s_vld}, {31'b0, vt[i].e_vld});
      chk($sformatf("vec%0d_count", i), {29'b0, s_cnt}, vt[i].e_cnt);
      if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), s_addr, vt[i].e_addr);
      if (vt[i].e_vld) begin
        chk($sformatf("vec%0d_pc", i), s_pc, vt[i].e_pc);
        chk($sformatf("vec%0d_inst", i), s_inst, 32'h1000_0000 | vt[i].e_pc);
      end
    end
    run(6);

    // Fresh reset, streaming at full rate with 1-cycle memory.
    rstn = 1'b0;
    cycle();
    rstn = 1'b1; ready = 1'b1; lat = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("stream_addr", s_addr, i);
      chk("stream_count_le1", {31'b0, (s_cnt <= 3'd1)}, 32'd1);
      if (i >= 2) begin
        chk("stream_pc", s_pc, i - 2);
        chk("stream_b_pc_wrap", {24'b0, s_bpc}, {24'b0, 8'hF8 + 8'(4 * (i - 2))});
      end
    end

    // Redirect while a response arrives and the head would be popped.
    redir = 1'b1; rpc = 32'h100;
    cycle();
    chk("redir_pending_count", {29'b0, s_cnt}, 32'd1);
    chk("redir_no_pop", {31'b0, s_vld}, 32'd0);
    chk("redir_no_req", {31'b0, s_req}, 32'd0);
    redir = 1'b0;
    cycle();
    chk("redir_next_addr", s_addr, 32'h100);
    chk("redir_next_req", {31'b0, s_req}, 32'd1);
    run_until_valid(10, "redir_t3", n);
    chk("redir_first_at_t3", n + 1, 32'd3);
    chk("redir_first_pc", s_pc, 32'h100);
    run(4);

    // 3-cycle memory, redirect with several words in flight.
    lat = 3;
    run(10);
    redir = 1'b1; rpc = 32'h40;
    cycle();
    redir = 1'b0;
    run_until_valid(20, "lat3_redir", n);
    chk("lat3_first_pc", s_pc, 32'h40);
    chk("lat3_first_inst", s_inst, 32'h1000_0040);
    run(8);

    // Two back-to-back redirects: only the second stream may appear.
    lat = 2;
    run(6);
    redir = 1'b1; rpc = 32'h20;
    cycle();
    rpc = 32'h80;
    cycle();
    redir = 1'b0;
    run_until_valid(20, "dbl_redir", n);
    chk("dbl_redir_first_pc", s_pc, 32'h80);
    run(8);

    // Random backpressure.
    for (int i = 0; i < 40; i++) begin
      ready = 1'($urandom_range(0, 1));
      cycle();
    end
    ready = 1'b1;
    run(8);

    // Reset pulse mid-stream with two words in flight; stale responses keep arriving.
    rstn = 1'b0;
    cycle();
    chk("rst_pulse_req", {31'b0, s_req}, 32'd0);
    chk("rst_pulse_valid", {31'b0, s_vld}, 32'd0);
    chk("rst_pulse_count", {29'b0, s_cnt}, 32'd0);
    rstn = 1'b1;
    cycle();
    chk("rst_restart_addr", s_addr, 32'h0);
    got = 0;
    for (int i = 0; i < 20 && got < 3; i++) begin
      cycle();
      if (s_vld) begin
        pa[got] = s_pc; pb[got] = s_bpc;
        got++;
      end
    end
    chk("rst_restart_got3", got, 32'd3);
    chk("rst_a_pc0", pa[0], 32'h0);
    chk("rst_a_pc1", pa[1], 32'h1);
    chk("rst_a_pc2", pa[2], 32'h2);
    chk("rst_b_pc0", {24'b0, pb[0]}, 32'hF8);
    chk("rst_b_pc1", {24'b0, pb[1]}, 32'hFC);
    chk("rst_b_pc2", {24'b0, pb[2]}, 32'h00);
    run(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
